// File: rtl/ifu_fill_ctrl.sv
// I-cache miss/fill initiator: one outstanding miss, single-cycle fill request,
// response matching with timeout and bounded retry, one-cycle line write.
module ifu_fill_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128,
  parameter int OFFSET_W  = 4,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [ADDR_W-1:0] mem_rsp_addr,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              fill_err,
  output logic              busy,
  output logic [CNT_W-1:0]  fill_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ADDR_W-1:0] LMASK =
    {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [RW-1:0]     rty_q, rty_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_hit;

  assign rsp_hit = mem_rsp_valid &&
                   ((mem_rsp_addr & LMASK) == line_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      rty_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    rty_d   = rty_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          line_d  = miss_addr & LMASK;
          rty_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a match beats a coincident timeout
        if (rsp_hit) begin
          data_d  = mem_rsp_data;
          state_d = S_FILL;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          if (rty_q < RW'(MAX_RETRY)) begin
            rty_d   = rty_q + 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FILL: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign miss_ready    = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = busy ? line_q : '0;
  assign fill_valid    = (state_q == S_FILL);
  assign fill_addr     = fill_valid ? line_q : '0;
  assign fill_data     = fill_valid ? data_q : '0;
  assign fill_err      = (state_q == S_ERR);
  assign fill_count    = cnt_q;

endmodule

// File: tb/tb_ifu_fill_ctrl.sv
// Bench for ifu_fill_ctrl: directed and random miss scenarios against a
// timeline model of request windows, matches, retries and errors.
module tb_ifu_fill_ctrl;

  localparam int T     = 16;
  localparam int P     = T + 1;
  localparam int MR    = 2;
  localparam int ERR_C = (MR + 1) * P;
  localparam logic [31:0] AMASK = 32'hFFFF_FFF0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid = 1'b0;
  logic [31:0]  mem_rsp_addr = '0;
  logic [127:0] mem_rsp_data = '0;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic         fill_err;
  logic         busy;
  logic [15:0]  fill_count;

  int vecs = 0;
  int errs = 0;
  int model_cnt = 0;

  logic         sv[64];
  logic [31:0]  sa[64];
  logic [127:0] sd[64];

  ifu_fill_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_addr     (miss_addr),
    .miss_ready    (miss_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_addr  (mem_rsp_addr),
    .mem_rsp_data  (mem_rsp_data),
    .fill_valid    (fill_valid),
    .fill_addr     (fill_addr),
    .fill_data     (fill_data),
    .fill_err      (fill_err),
    .busy          (busy),
    .fill_count    (fill_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < 64; i++) begin
      sv[i] = 1'b0;
      sa[i] = '0;
      sd[i] = '0;
    end
  endtask

  task automatic add_rsp(input int c, input logic [31:0] a,
                         input logic [127:0] d);
    sv[c] = 1'b1;
    sa[c] = a;
    sd[c] = d;
  endtask

  // Cycle 0 is the first request; attempt k requests at k*P and listens on
  // the following T cycles. First matching response in a listen window wins.
  function automatic int model_hit(input logic [31:0] line);
    for (int c = 1; c < ERR_C; c++)
      if (sv[c] && ((sa[c] & AMASK) == line) && (c % P != 0))
        return c;
    return -1;
  endfunction

  task automatic run_miss(input logic [31:0] addr, input string tag);
    logic [31:0]  line;
    logic [31:0]  f_addr;
    logic [127:0] f_data;
    int hit, end_c, exp_pulses;
    int pulses[$];
    int nfill, nerr, fill_c, err_c, busy_bad;
    bit addr_bad, exp_b, sp_bad;
    line       = addr & AMASK;
    hit        = model_hit(line);
    end_c      = (hit >= 0) ? hit + 1 : ERR_C;
    exp_pulses = (hit >= 0) ? hit / P + 1 : MR + 1;
    nfill = 0; nerr = 0; fill_c = -1; err_c = -1; busy_bad = 0;
    addr_bad = 1'b0; f_addr = 'x; f_data = 'x;

    @(negedge clk);
    vecs++;
    if (miss_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s miss_ready_idle got=%b want=1", tag, miss_ready);
    end
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    miss_valid = 1'b0;
    miss_addr  = $urandom;

    for (int c = 0; c <= end_c + 1; c++) begin
      if (mem_req_valid === 1'b1) begin
        pulses.push_back(c);
        if (mem_req_addr !== line) addr_bad = 1'b1;
      end
      if (fill_valid === 1'b1) begin
        nfill++;
        fill_c = c;
        f_addr = fill_addr;
        f_data = fill_data;
      end
      if (fill_err === 1'b1) begin
        nerr++;
        err_c = c;
      end
      exp_b = (c <= end_c);
      if (busy !== exp_b || miss_ready !== !exp_b) busy_bad++;
      if (!exp_b && mem_req_addr !== 32'h0) busy_bad++;
      mem_rsp_valid = sv[c];
      mem_rsp_addr  = sv[c] ? sa[c] : $urandom;
      mem_rsp_data  = sv[c] ? sd[c] : rnd128();
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;

    vecs++;
    if (pulses.size() != exp_pulses) begin
      errs++;
      $display("FAIL %s req_pulses got=%0d want=%0d", tag,
               pulses.size(), exp_pulses);
    end
    vecs++;
    sp_bad = 1'b0;
    foreach (pulses[k]) if (pulses[k] != k * P) sp_bad = 1'b1;
    if (sp_bad) begin
      errs++;
      $display("FAIL %s req_spacing got_first=%0d got_last=%0d want_step=%0d",
               tag, pulses.size() ? pulses[0] : -1,
               pulses.size() ? pulses[$] : -1, P);
    end
    vecs++;
    if (addr_bad) begin
      errs++;
      $display("FAIL %s req_addr got=mismatch want=%h", tag, line);
    end
    if (hit >= 0) begin
      model_cnt++;
      vecs++;
      if (nfill != 1 || fill_c != end_c) begin
        errs++;
        $display("FAIL %s fill_cycle got=%0d(n=%0d) want=%0d", tag,
                 fill_c, nfill, end_c);
      end
      vecs++;
      if (f_addr !== line) begin
        errs++;
        $display("FAIL %s fill_addr got=%h want=%h", tag, f_addr, line);
      end
      vecs++;
      if (f_data !== sd[hit]) begin
        errs++;
        $display("FAIL %s fill_data got=%h want=%h", tag, f_data, sd[hit]);
      end
      vecs++;
      if (nerr != 0) begin
        errs++;
        $display("FAIL %s fill_err got=%0d pulses want=0", tag, nerr);
      end
    end else begin
      vecs++;
      if (nfill != 0) begin
        errs++;
        $display("FAIL %s no_fill got=%0d pulses want=0", tag, nfill);
      end
      vecs++;
      if (nerr != 1 || err_c != ERR_C) begin
        errs++;
        $display("FAIL %s err_cycle got=%0d(n=%0d) want=%0d", tag,
                 err_c, nerr, ERR_C);
      end
    end
    vecs++;
    if (busy_bad != 0) begin
      errs++;
      $display("FAIL %s busy_profile got=%0d bad cycles want=0", tag, busy_bad);
    end
    vecs++;
    if (fill_count !== 16'(model_cnt)) begin
      errs++;
      $display("FAIL %s fill_count got=%0d want=%0d", tag, fill_count,
               16'(model_cnt));
    end
  endtask

  task automatic check_idle(input string tag);
    vecs++;
    if (mem_req_valid !== 1'b0 || fill_valid !== 1'b0 ||
        fill_err !== 1'b0 || busy !== 1'b0 || miss_ready !== 1'b1 ||
        mem_req_addr !== 32'h0 || fill_addr !== 32'h0 ||
        fill_data !== 128'h0) begin
      errs++;
      $display("FAIL %s idle_outputs got=req%b fv%b fe%b b%b mr%b a%h want=idle",
               tag, mem_req_valid, fill_valid, fill_err, busy, miss_ready,
               mem_req_addr);
    end
    vecs++;
    if (fill_count !== 16'(model_cnt)) begin
      errs++;
      $display("FAIL %s fill_count got=%0d want=%0d", tag, fill_count,
               16'(model_cnt));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_held");
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset_released");
    end
  endtask

  task automatic test_basic();
    clear_sched();
    add_rsp(7, 32'h10, {32'h4, 32'h3, 32'h2, 32'h1});
    run_miss(32'h13, "basic");
  endtask

  task automatic test_stale();
    clear_sched();
    add_rsp(3, 32'h10, rnd128());
    add_rsp(6, 32'h20, {4{32'hA5A5_A5A5}});
    run_miss(32'h20, "stale");
  endtask

  task automatic test_timeout();
    clear_sched();
    run_miss(32'h40, "timeout");
  endtask

  task automatic test_race();
    clear_sched();
    add_rsp(T, 32'h6C, rnd128());
    run_miss(32'h64, "race_first");
    clear_sched();
    add_rsp(0, 32'h70, rnd128());
    add_rsp(ERR_C - 1, 32'h7F, rnd128());
    run_miss(32'h78, "race_last");
  endtask

  task automatic test_back_to_back();
    clear_sched();
    add_rsp(1, 32'h80, rnd128());
    run_miss(32'h84, "b2b_a");
    clear_sched();
    add_rsp(2, 32'h90, rnd128());
    run_miss(32'h9F, "b2b_b");
  endtask

  task automatic test_random();
    logic [31:0] a, line;
    int n;
    for (int it = 0; it < 24; it++) begin
      clear_sched();
      a    = $urandom;
      line = a & AMASK;
      n    = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 1) == 1)
          add_rsp($urandom_range(0, 55), line | 32'($urandom_range(0, 15)),
                  rnd128());
        else
          add_rsp($urandom_range(0, 55),
                  line ^ {$urandom_range(1, 255), 4'h0}, rnd128());
      end
      run_miss(a, $sformatf("random%0d", it));
    end
  endtask

  task automatic test_reset_mid();
    bit late_bad;
    clear_sched();
    @(negedge clk);
    miss_valid = 1'b1;
    miss_addr  = 32'h30;
    @(posedge clk);
    @(negedge clk);
    miss_valid = 1'b0;
    repeat (4) @(negedge clk);
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid busy_before got=%b want=1", busy);
    end
    rst = 1'b0;
    model_cnt = 0;
    #1;
    check_idle("reset_mid_async");
    @(negedge clk);
    rst = 1'b1;
    late_bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_addr  = 32'h30;
      mem_rsp_data  = rnd128();
      @(negedge clk);
      if (fill_valid !== 1'b0 || busy !== 1'b0 || fill_err !== 1'b0)
        late_bad = 1'b1;
    end
    mem_rsp_valid = 1'b0;
    vecs++;
    if (late_bad) begin
      errs++;
      $display("FAIL reset_mid late_rsp got=activity want=ignored");
    end
    check_idle("reset_mid_after");
    clear_sched();
    add_rsp(5, 32'h50, rnd128());
    run_miss(32'h50, "reset_mid_next");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale();
    test_timeout();
    test_race();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ifu_fill_ctrl.md
Name: ifu_fill_ctrl

Overview:
Instruction-cache miss/fill initiator: the requester end of the cache-to-i_mem fill interface. It accepts one miss at a time from the i-cache lookup stage and issues a single-cycle fill request (line-aligned address) toward i_mem_wrap. It waits for the matching fill response, with timeout and bounded retry, then delivers the line to the cache data array as a one-cycle write pulse.

Parameters:
ADDR_W, 32, address width (matches fill_requested_address)
LINE_W, 128, cache line width in bits
OFFSET_W, 4, log2(line bytes); low OFFSET_W address bits are zeroed on request
TIMEOUT, 16, WAIT cycles without a matching response before a retry
MAX_RETRY, 2, retries after the first request before declaring error
CNT_W, 16, width of the fill statistics counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset)
miss_valid  in  1  miss request from cache lookup
miss_addr  in  ADDR_W  miss address (any byte offset)
miss_ready  out  1  controller can accept a miss
mem_req_valid  out  1  fill request valid (drives fill_requested_address_valid)
mem_req_addr  out  ADDR_W  line-aligned fill address (drives fill_requested_address)
mem_rsp_valid  in  1  fill response valid from i_mem
mem_rsp_addr  in  ADDR_W  address the response belongs to
mem_rsp_data  in  LINE_W  returned line
fill_valid  out  1  one-cycle cache line write strobe
fill_addr  out  ADDR_W  line-aligned address for the write
fill_data  out  LINE_W  line data for the write
fill_err  out  1  one-cycle pulse: fill abandoned after retries
busy  out  1  state != IDLE
fill_count  out  CNT_W  successful fills since reset, wraps at 2^CNT_W

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 except miss_ready=1. Retry and timeout counters are cleared.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- States: IDLE, REQ, WAIT, FILL, ERR.
- IDLE:
  - miss_ready=1.
  - On miss_valid&&miss_ready at edge N: latch line_addr = miss_addr with low OFFSET_W bits zeroed. Clear the retry count. Go to REQ.
- REQ (cycle N+1):
  - mem_req_valid=1 for exactly this cycle. mem_req_addr=line_addr.
  - Clear the timeout count. Go to WAIT.
- mem_req_addr holds line_addr from REQ until the return to IDLE. It is 0 in IDLE.
- WAIT: responses are sampled only in WAIT; a response in the REQ cycle is ignored.
  - A match requires mem_rsp_valid=1 and (mem_rsp_addr with low OFFSET_W bits zeroed) == line_addr.
  - On a match: capture mem_rsp_data and go to FILL.
  - Non-matching responses (stale, or from earlier retries) are ignored and do not reset the timeout count.
  - Otherwise the timeout count increments each WAIT cycle. On the TIMEOUT-th WAIT cycle with no match:
    - retry count < MAX_RETRY: increment the retry count, go to REQ. Request pulses are spaced TIMEOUT+1 cycles apart.
    - else: go to ERR.
  - A matching response in the same cycle as the timeout wins: go to FILL, no retry.
- FILL:
  - fill_valid=1 for one cycle; fill_addr=line_addr; fill_data=captured line.
  - fill_count increments (wrapping). Go to IDLE.
- ERR: fill_err=1 for one cycle; fill_count unchanged; go to IDLE.
- Latency: with i_mem response latency L cycles after the REQ cycle, fill_valid asserts at cycle N+2+L.
- miss_ready=0 in every state but IDLE. There is a single outstanding miss; no queueing. A miss presented while busy is held off by the requester.
- A late response to an abandoned request arriving in IDLE is ignored.
- Reset asserted mid-operation:
  - Immediate return to IDLE with reset outputs.
  - In-flight data is discarded; no fill_valid and no fill_err for that miss.
  - fill_count clears to 0.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> mem_req_valid=0, fill_valid=0, fill_err=0, busy=0, fill_count=0, miss_ready=1; after release all hold until a miss arrives.
- Basic fill: miss_addr=0x0000_0013 with i_mem preloaded words 1,2,3,4 and L=7 -> one mem_req_valid pulse with mem_req_addr=0x10; fill_valid for exactly 1 cycle at N+9; fill_addr=0x10; fill_data=0x00000004_00000003_00000002_00000001; fill_count=1; miss_ready back to 1 the next cycle.
- Stale response: miss 0x20; a response with addr 0x10 at WAIT cycle 3, then addr 0x20 data 0xA5.. at cycle 6 -> first ignored; fill_valid with fill_addr=0x20 and data 0xA5..; no retry pulse.
- Timeout/retry/error: miss 0x40, no response, TIMEOUT=16, MAX_RETRY=2 -> exactly 3 request pulses, 17 cycles apart, all addr 0x40; then one fill_err pulse; back to IDLE; fill_count unchanged.
- Race: matching response exactly on the 16th WAIT cycle -> fill_valid next cycle, no second request pulse, fill_err stays 0.
- Reset mid-WAIT: miss 0x30, assert rst=0 at WAIT cycle 4, release, then drive a response with addr 0x30 -> outputs reset immediately; late response ignored; no fill_valid; a new miss 0x50 afterwards completes normally.
